// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between ifetch and data.
// Optional ARB_ROUND_ROBIN_EN selects alternating priority on contention.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    imem_valid_i,
    output logic                    imem_ready_o,
    input  logic [ADDR_WIDTH-1:0]   imem_addr_i,
    input  logic [DATA_WIDTH-1:0]   imem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] imem_we_i,
    output logic [DATA_WIDTH-1:0]   imem_rdata_o,

    input  logic                    dmem_valid_i,
    output logic                    dmem_ready_o,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dmem_we_i,
    output logic [DATA_WIDTH-1:0]   dmem_rdata_o,

    output logic                    mem_valid_o,
    input  logic                    mem_ready_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_we_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,

    output logic [1:0]              grant_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   pick_d;

`ifdef ARB_ROUND_ROBIN_EN
    // 0: instruction port won last, 1: data port won last
    logic last_grant;

    // Data wins contention only if instruction won the previous grant
    always_comb begin
        pick_d = dmem_valid_i && (!imem_valid_i || !last_grant);
    end

    // Remember the owner on every entry into a grant state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b0;
        end else if (state == IDLE && state_nxt != IDLE) begin
            last_grant <= (state_nxt == GNT_D);
        end
    end
`else
    // Fixed priority: the data port always wins contention
    always_comb begin
        pick_d = dmem_valid_i;
    end
`endif

    // State register; reset drops any grant immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: arbitrate in IDLE, release on completion or abort
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    state_nxt = GNT_D;
                end else if (imem_valid_i) begin
                    state_nxt = GNT_I;
                end
            end
            GNT_I: begin
                if (!imem_valid_i || mem_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            GNT_D: begin
                if (!dmem_valid_i || mem_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-side mux and owner-only ready, all decoded from the state
    always_comb begin
        mem_valid_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_we_o     = '0;
        imem_ready_o = 1'b0;
        dmem_ready_o = 1'b0;
        case (state)
            GNT_I: begin
                mem_valid_o  = imem_valid_i;
                mem_addr_o   = imem_addr_i;
                mem_wdata_o  = imem_wdata_i;
                mem_we_o     = imem_we_i;
                imem_ready_o = imem_valid_i && mem_ready_i;
            end
            GNT_D: begin
                mem_valid_o  = dmem_valid_i;
                mem_addr_o   = dmem_addr_i;
                mem_wdata_o  = dmem_wdata_i;
                mem_we_o     = dmem_we_i;
                dmem_ready_o = dmem_valid_i && mem_ready_i;
            end
            default: begin
                mem_valid_o = 1'b0;
            end
        endcase
    end

    // Read data fans out to both ports; ready qualifies it
    assign imem_rdata_o = mem_rdata_i;
    assign dmem_rdata_o = mem_rdata_i;

    assign grant_o = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios then random traffic
// against a transaction-level ownership model of the arbiter.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        iv, dv, mv, mrdy;
    logic        irdy, drdy;
    logic [31:0] ia, iw, da, dw, ma, mw, mrd;
    logic [31:0] ird, drd;
    logic [3:0]  iwe, dwe, mwe;
    logic [1:0]  gnt;

    int vectors;
    int miscompares;

    // Model: who holds the memory (0 none, 1 instr, 2 data)
    int m_owner;
    bit m_d_last;
    bit e_irdy, e_drdy;
    int n_irdy, n_drdy;
    bit i_pend, d_pend;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
    localparam int EXP_D = 3;
`else
    localparam bit RR = 1'b0;
    localparam int EXP_D = 6;
`endif

    mem_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_valid_i (iv),
        .imem_ready_o (irdy),
        .imem_addr_i  (ia),
        .imem_wdata_i (iw),
        .imem_we_i    (iwe),
        .imem_rdata_o (ird),
        .dmem_valid_i (dv),
        .dmem_ready_o (drdy),
        .dmem_addr_i  (da),
        .dmem_wdata_i (dw),
        .dmem_we_i    (dwe),
        .dmem_rdata_o (drd),
        .mem_valid_o  (mv),
        .mem_ready_i  (mrdy),
        .mem_addr_o   (ma),
        .mem_wdata_o  (mw),
        .mem_we_o     (mwe),
        .mem_rdata_i  (mrd),
        .grant_o      (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_d_last = 1'b0;
    endtask

    // Called just after a negedge with inputs applied: check, clock, update
    task automatic cyc();
        logic        e_mv;
        logic [31:0] e_a, e_w;
        logic [3:0]  e_we;
        #1;
        e_mv = (m_owner == 1) ? iv : (m_owner == 2) ? dv : 1'b0;
        e_a  = (m_owner == 1) ? ia : (m_owner == 2) ? da : 32'h0;
        e_w  = (m_owner == 1) ? iw : (m_owner == 2) ? dw : 32'h0;
        e_we = (m_owner == 1) ? iwe : (m_owner == 2) ? dwe : 4'h0;
        e_irdy = (m_owner == 1) && iv && mrdy;
        e_drdy = (m_owner == 2) && dv && mrdy;
        chk("grant", 64'(gnt), 64'(m_owner));
        chk("mem_valid", 64'(mv), 64'(e_mv));
        chk("mem_addr", 64'(ma), 64'(e_a));
        chk("mem_wdata", 64'(mw), 64'(e_w));
        chk("mem_we", 64'(mwe), 64'(e_we));
        chk("imem_ready", 64'(irdy), 64'(e_irdy));
        chk("dmem_ready", 64'(drdy), 64'(e_drdy));
        chk("imem_rdata", 64'(ird), 64'(mrd));
        chk("dmem_rdata", 64'(drd), 64'(mrd));
        if (irdy) n_irdy++;
        if (drdy) n_drdy++;
        @(posedge clk);
        if (m_owner == 1) begin
            if (!iv || mrdy) m_owner = 0;
        end else if (m_owner == 2) begin
            if (!dv || mrdy) m_owner = 0;
        end else begin
            if (iv && dv)
                m_owner = (RR && m_d_last) ? 1 : 2;
            else if (iv)
                m_owner = 1;
            else if (dv)
                m_owner = 2;
            if (m_owner != 0) m_d_last = (m_owner == 2);
        end
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_mv"}, 64'(mv), 64'(0));
        chk({tag, "_irdy"}, 64'(irdy), 64'(0));
        chk({tag, "_drdy"}, 64'(drdy), 64'(0));
        chk({tag, "_gnt"}, 64'(gnt), 64'(0));
    endtask

    initial begin
        int di, dd;
        vectors = 0;
        miscompares = 0;
        n_irdy = 0;
        n_drdy = 0;
        rst_n = 1'b0;
        iv = 0; dv = 0; mrdy = 0;
        ia = 0; iw = 0; iwe = 0;
        da = 0; dw = 0; dwe = 0;
        mrd = 0;
        model_reset();
        #2;
        check_idle_outputs("reset");
        chk("reset_addr", 64'(ma), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single fetch, zero-wait memory
        iv = 1; ia = 32'h100; mrdy = 1; mrd = 32'h13;
        cyc();
        cyc();
        chk("fetch_done", 64'(n_irdy), 64'(1));
        iv = 0; mrdy = 0;
        cyc();

        // Data write with three wait states
        di = n_irdy; dd = n_drdy;
        dv = 1; da = 32'h200; dw = 32'hDEADBEEF; dwe = 4'hF;
        mrdy = 0; mrd = 32'h55AA55AA;
        cyc();
        repeat (3) cyc();
        mrdy = 1;
        cyc();
        dv = 0; mrdy = 0;
        cyc();
        chk("write_drdy_once", 64'(n_drdy - dd), 64'(1));
        chk("write_no_irdy", 64'(n_irdy - di), 64'(0));

        // Contention from a fresh reset
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        di = n_irdy; dd = n_drdy;
        iv = 1; ia = 32'h300; iw = 32'h0; iwe = 4'h0;
        dv = 1; da = 32'h400; dw = 32'h1234; dwe = 4'h3;
        mrdy = 1;
        repeat (12) begin
            mrd = $urandom;
            cyc();
        end
        chk("contend_data", 64'(n_drdy - dd), 64'(EXP_D));
        chk("contend_instr", 64'(n_irdy - di), 64'(6 - EXP_D));
        iv = 0; dv = 0; mrdy = 0;
        cyc();

        // Abort: instruction valid drops while granted
        di = n_irdy;
        iv = 1; ia = 32'h500; mrdy = 0;
        cyc();
        cyc();
        iv = 0;
        #1;
        chk("abort_mv", 64'(mv), 64'(0));
        cyc();
        cyc();
        chk("abort_no_irdy", 64'(n_irdy - di), 64'(0));

        // Asynchronous reset in the middle of a data grant
        dv = 1; da = 32'h600; mrdy = 0;
        cyc();
        mrdy = 1;
        #1;
        chk("pre_rst_gnt", 64'(gnt), 64'(2));
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        model_reset();
        dv = 0; mrdy = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with random wait states and rare aborts
        i_pend = 0;
        d_pend = 0;
        for (int c = 0; c < 600; c++) begin
            if (!i_pend && $urandom_range(2) == 0) begin
                i_pend = 1;
                ia = $urandom; iw = $urandom;
                iwe = 4'($urandom);
            end
            if (!d_pend && $urandom_range(2) == 0) begin
                d_pend = 1;
                da = $urandom; dw = $urandom;
                dwe = 4'($urandom);
            end
            if (i_pend && m_owner == 1 && $urandom_range(15) == 0)
                i_pend = 0;
            if (d_pend && m_owner == 2 && $urandom_range(15) == 0)
                d_pend = 0;
            iv = i_pend;
            dv = d_pend;
            mrdy = 1'($urandom);
            mrd = $urandom;
            cyc();
            if (e_irdy) i_pend = 0;
            if (e_drdy) d_pend = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-into-one arbiter that shares one single-port memory between the core's instruction-fetch port and data port. Sits between `riscv_core` and a single-port RAM, replacing the dual-port `dp_ram` wiring in small configurations. Both requester sides and the memory side use the core's valid/ready word handshake. One winner is held on the memory port until its access completes.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: address width on all ports.
- `DATA_WIDTH`, 32: data word width; `we` is `DATA_WIDTH/8` bits.

Ports:
- `clk`  in  1  clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_valid_i` / `imem_ready_o`  in / out  1  instruction-port handshake.
- `imem_addr_i`, `imem_wdata_i`, `imem_we_i`  in  ADDR / DATA / DATA/8  instruction-port request.
- `imem_rdata_o`  out  DATA  instruction read data.
- `dmem_valid_i` / `dmem_ready_o`  in / out  1  data-port handshake.
- `dmem_addr_i`, `dmem_wdata_i`, `dmem_we_i`  in  ADDR / DATA / DATA/8  data-port request.
- `dmem_rdata_o`  out  DATA  data read data.
- `mem_valid_o` / `mem_ready_i`  out / in  1  memory-side handshake.
- `mem_addr_o`, `mem_wdata_o`, `mem_we_o`  out  ADDR / DATA / DATA/8  muxed request.
- `mem_rdata_i`  in  DATA  memory read data.
- `grant_o`  out  2  current owner: 2'b00 none, 2'b01 instruction, 2'b10 data.

## Operation
- The FSM has three states: IDLE, GNT_I, GNT_D. The reset state is IDLE.
- In IDLE:
  - No valid: stay in IDLE.
  - Exactly one valid: move to that requester's grant state.
  - Both valid: the priority rule picks the winner (see Configuration).
- In GNT_x:
  - `mem_valid_o` = `x_valid_i`. Addr, wdata and we are muxed from x.
  - The other requester sees ready=0.
- Completion: when `mem_ready_i` && `mem_valid_o`:
  - `x_ready_o` = 1 for that cycle, `x_rdata_o` = `mem_rdata_i`.
  - The FSM returns to IDLE.
- Abort: if `x_valid_i` drops while in GNT_x (protocol violation), `mem_valid_o` drops in the same cycle and the FSM returns to IDLE. No ready is issued.
- Non-owner read data: the non-owner `rdata` output is driven with `mem_rdata_i` but is meaningless, because its ready is 0.
- Writes and reads are treated identically. `we` passes through unchanged.
- Requester obligations: hold valid and request fields stable until its ready is seen.

## Timing
- Outputs in reset and in IDLE: `mem_valid_o`=0, `imem_ready_o`=0, `dmem_ready_o`=0, `grant_o`=2'b00. Data outputs are don't-care, but the implementation drives 0 for mem addr/wdata/we.
- Arbitration is registered. A request seen in IDLE at cycle N drives `mem_valid_o` in cycle N+1. Minimum access latency is 2 cycles from valid to ready with a zero-wait memory.
- Back-to-back accesses: after completion the FSM spends one IDLE cycle. Peak throughput is one access per 2 cycles.
- `x_ready_o` is combinational from `mem_ready_i` and is never asserted outside the owner's grant state.
- `grant_o` is registered and equals the FSM state encoding.
- A reset asserted mid-grant forces IDLE immediately. No ready is issued to the interrupted requester.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit `last_grant` register (reset = instruction) records the most recent owner.
  - On contention, the requester that did not win last time wins.
  - `last_grant` updates on every entry into a grant state.
- `ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: data port always wins contention.
  - No `last_grant` register.
  - Instruction fetch can starve while data requests continue back to back.

## Test plan
- Single fetch: `imem_valid_i`=1, addr 0x100, memory returns 0x00000013 with 0 wait. Required: `mem_valid_o` at cycle 1, `mem_addr_o`=0x100, `imem_ready_o`=1 and `imem_rdata_o`=0x00000013 at cycle 1, `grant_o`=2'b01 at cycle 1.
- Data write with wait states: `dmem` addr 0x200, wdata 0xDEADBEEF, we 4'b1111, `mem_ready_i` held low 3 cycles. Required: mem fields stable through the wait, `dmem_ready_o` pulses exactly once, then IDLE. `imem_ready_o` stays 0 throughout.
- Contention, macro undefined: both valid continuously for 6 accesses. Required: every grant goes to data, `grant_o` reads 10,00,10,00,…
- Contention, `ARB_ROUND_ROBIN_EN` defined: both valid continuously. Required: first grant data (last_grant reset = instruction), then grants alternate I/D, giving 3 and 3 over 6 accesses.
- Abort: drop `imem_valid_i` one cycle into GNT_I with `mem_ready_i`=0. Required: `mem_valid_o`=0 in the same cycle, no `imem_ready_o`, `grant_o`=00 next cycle.
- Reset mid-access: assert `rst_n`=0 asynchronously during GNT_D. Required: `mem_valid_o`, both readies and `grant_o` go to 0 without waiting for a clock edge.
